// File: rtl/twos_comp_deser_if.sv
// Serial link bundle for twos_comp_deser: the complemented bit stream in, the decoded parallel word and flags out.
// The master modport drives the serial stream; the slave modport is the receiver.
interface twos_comp_deser_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_sof;
    logic             incode;
    logic [WIDTH-1:0] out_word;
    logic             out_valid;
    logic             out_minval;
    logic             out_err;

    modport master (
        output in_valid,
        output in_sof,
        output incode,
        input  out_word,
        input  out_valid,
        input  out_minval,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  incode,
        output out_word,
        output out_valid,
        output out_minval,
        output out_err
    );
endinterface

// File: rtl/twos_comp_deser.sv
// Deserialiser for an LSB-first, bit-serial two's-complement stream. It passes bits up to and including
// the first 1, inverts every later bit, and assembles WIDTH decoded bits into a parallel word.
module twos_comp_deser #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    twos_comp_deser_if.slave   bus
);
    localparam int                CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST   = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]  MINVAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS   = 2'd1,
        INVERT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             vld_q, vld_d;
    logic             minval_q, minval_d;
    logic             err_q, err_d;
    logic             dec_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            word_q   <= '0;
            vld_q    <= 1'b0;
            minval_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            word_q   <= word_d;
            vld_q    <= vld_d;
            minval_q <= minval_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        word_d   = word_q;
        vld_d    = 1'b0;
        minval_d = 1'b0;
        err_d    = 1'b0;
        dec_bit  = bus.incode;

        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // Bit 0 always passes through; a frame in flight is abandoned and flagged.
                err_d   = (state_q != IDLE);
                sr_d    = {bus.incode, sr_q[WIDTH-1:1]};
                cnt_d   = CNT_W'(1);
                state_d = bus.incode ? INVERT : PASS;
            end else if (state_q != IDLE) begin
                dec_bit = (state_q == INVERT) ? ~bus.incode : bus.incode;
                sr_d    = {dec_bit, sr_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    word_d   = sr_d;
                    vld_d    = 1'b1;
                    minval_d = (sr_d == MINVAL);
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((state_q == PASS) && bus.incode) begin
                        state_d = INVERT;
                    end
                end
            end
        end
    end

    assign bus.out_word   = word_q;
    assign bus.out_valid  = vld_q;
    assign bus.out_minval = minval_q;
    assign bus.out_err    = err_q;
endmodule

// File: tb/tb_twos_comp_deser.sv
// Bench for twos_comp_deser: a frame-level model (decoded word = negation of the received code word)
// checked every cycle, plus literal expectations for each directed scenario.
module tb_twos_comp_deser;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    twos_comp_deser_if #(.WIDTH(W)) bus_if ();

    twos_comp_deser #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state, advanced on each rising edge from the inputs the DUT sees.
    logic [W-1:0] m_enc = '0;
    int           m_n = 0;
    bit           m_inframe = 1'b0;
    logic [W-1:0] exp_word = '0;
    logic         exp_valid = 1'b0;
    logic         exp_minval = 1'b0;
    logic         exp_err = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            exp_valid  = 1'b0;
            exp_err    = 1'b0;
            exp_minval = 1'b0;
            if (rst) begin
                m_inframe = 1'b0;
                m_n       = 0;
                exp_word  = '0;
            end else if (bus_if.in_valid) begin
                if (bus_if.in_sof) begin
                    exp_err   = m_inframe;
                    m_inframe = 1'b1;
                    m_enc     = '0;
                    m_n       = 0;
                end
                if (m_inframe) begin
                    m_enc[m_n] = bus_if.incode;
                    m_n++;
                    if (m_n == W) begin
                        exp_word   = -m_enc;
                        exp_valid  = 1'b1;
                        exp_minval = (exp_word == {1'b1, {(W-1){1'b0}}});
                        m_inframe  = 1'b0;
                    end
                end
            end
        end
    end

    // Per-cycle comparison and bookkeeping for the literal checks.
    int           cyc = 0;
    int           valid_cnt = 0;
    int           err_cnt = 0;
    int           last_valid_cyc = 0;
    int           valid_gap = 0;
    logic [W-1:0] last_word = '0;
    logic         last_minval = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("out_valid", 32'(bus_if.out_valid), 32'(exp_valid));
            chk("out_err", 32'(bus_if.out_err), 32'(exp_err));
            chk("out_word", 32'(bus_if.out_word), 32'(exp_word));
            if (exp_valid) begin
                chk("out_minval", 32'(bus_if.out_minval), 32'(exp_minval));
            end
            if (bus_if.out_valid === 1'b1) begin
                valid_cnt++;
                valid_gap      = cyc - last_valid_cyc;
                last_valid_cyc = cyc;
                last_word      = bus_if.out_word;
                last_minval    = bus_if.out_minval;
            end
            if (bus_if.out_err === 1'b1) err_cnt++;
        end
    end

    task automatic send_bit(input logic v, input logic sof, input logic b);
        @(negedge clk);
        bus_if.in_valid = v;
        bus_if.in_sof   = sof;
        bus_if.incode   = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b0, 1'b0);
    endtask

    // Sends a code word LSB first; max_gap > 0 inserts 1..max_gap stall cycles before each bit,
    // with in_sof toggled randomly while in_valid is low.
    task automatic send_word(input logic [W-1:0] enc, input int max_gap);
        for (int i = 0; i < W; i++) begin
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(1, max_gap);
                for (int k = 0; k < g; k++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            send_bit(1'b1, (i == 0), enc[i]);
        end
    endtask

    int v0, e0;

    initial begin
        bus_if.in_valid = 1'b0;
        bus_if.in_sof   = 1'b0;
        bus_if.incode   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_word", 32'(bus_if.out_word), 32'h0);
        chk("rst_valid", 32'(bus_if.out_valid), 32'h0);
        chk("rst_minval", 32'(bus_if.out_minval), 32'h0);
        chk("rst_err", 32'(bus_if.out_err), 32'h0);
        rst = 1'b0;

        // 0xFD decodes to 0x03
        v0 = valid_cnt;
        send_word(8'hFD, 0);
        idle(2);
        chk("fd_word", 32'(last_word), 32'h03);
        chk("fd_minval", 32'(last_minval), 32'h0);
        chk("fd_count", 32'(valid_cnt - v0), 32'd1);

        // Zero word, then back-to-back minimum value
        send_word(8'h00, 0);
        send_word(8'h80, 0);
        idle(2);
        chk("b2b_gap", 32'(valid_gap), 32'd8);
        chk("min_word", 32'(last_word), 32'h80);
        chk("min_flag", 32'(last_minval), 32'h1);

        // Stalled frame
        v0 = valid_cnt;
        send_word(8'hFD, 5);
        idle(2);
        chk("stall_word", 32'(last_word), 32'h03);
        chk("stall_count", 32'(valid_cnt - v0), 32'd1);

        // Abort after 3 bits, restart with 0xFE
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        send_word(8'hFE, 0);
        idle(2);
        chk("abort_err", 32'(err_cnt - e0), 32'd1);
        chk("abort_count", 32'(valid_cnt - v0), 32'd1);
        chk("abort_word", 32'(last_word), 32'h02);

        // Bits without start-of-frame while idle
        v0 = valid_cnt;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 1'(i % 3 == 0));
        idle(2);
        chk("nosof_count", 32'(valid_cnt - v0), 32'd0);
        chk("nosof_word", 32'(bus_if.out_word), 32'h02);

        // Reset in the middle of a frame
        e0 = err_cnt;
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.in_sof   = 1'b0;
        bus_if.incode   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("mrst_word", 32'(bus_if.out_word), 32'h0);
        chk("mrst_valid", 32'(bus_if.out_valid), 32'h0);
        chk("mrst_err", 32'(bus_if.out_err), 32'h0);
        v0 = valid_cnt;
        send_word(8'hFD, 0);
        idle(3);
        chk("mrst_noerr", 32'(err_cnt - e0), 32'd0);
        chk("post_rst_word", 32'(last_word), 32'h03);
        chk("post_rst_count", 32'(valid_cnt - v0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/twos_comp_deser.md
# twos_comp_deser

Serial-to-parallel receiver for the LSB-first two's-complement bit stream produced by the serial `twos_comp` FSM. It applies the same bit-serial complement rule to recover the original word: pass bits through up to and including the first `1`, then invert every later bit. It assembles each frame into a parallel word and flags framing errors and the self-complementing minimum value. It sits at the far end of the serial link, feeding parallel consumers.

## Interface
- `WIDTH`, default 8, word length in bits; must be ≥ 2.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `incode` carries a valid bit this cycle.
- `in_sof` input 1: start of frame; qualified by `in_valid`; marks bit 0 (LSB).
- `incode` input 1: serial complemented data, LSB first.
- `out_word` output WIDTH: last fully decoded word; holds until the next completion.
- `out_valid` output 1: one-cycle pulse when `out_word` updates.
- `out_minval` output 1: valid with `out_valid`; decoded word is 1 followed by WIDTH-1 zeros (self-complement case).
- `out_err` output 1: one-cycle pulse; the current frame was aborted by a new `in_sof`.

## Operation
- States:
  - IDLE: no frame in progress.
  - PASS: in a frame, no `1` seen yet.
  - INVERT: in a frame, a `1` has been seen.
- An accepted bit is a cycle with `in_valid` = 1.
  - Decoded bit = `incode` in PASS, including the first `1`.
  - Decoded bit = `~incode` in INVERT.
- IDLE:
  - Accepted bit with `in_sof` = 1 starts a frame and is bit 0.
  - Next state is INVERT if `incode` = 1, otherwise PASS.
  - Accepted bits without `in_sof` are discarded.
- PASS:
  - Accepted bit with `incode` = 1 moves to INVERT.
  - Accepted bit with `incode` = 0 stays in PASS.
- Shift register: `sr <= {dec_bit, sr[WIDTH-1:1]}` on each accepted bit. The LSB ends in `sr[0]` after WIDTH bits.
- Bit counter runs 0..WIDTH-1.
  - On the accepted bit with count = WIDTH-1, the frame completes.
  - Next cycle: `out_word` = assembled word, `out_valid` = 1, `out_minval` computed from that word.
  - State returns to IDLE.
- `in_valid` = 0 mid-frame: stall. State, counter and shift register hold. Gaps of any length are allowed.
- `in_sof` = 1 with `in_valid` = 1 mid-frame (count ≠ 0):
  - Partial frame is dropped and `out_err` pulses next cycle.
  - The same bit restarts the frame as bit 0. No `out_valid` for the dropped frame.
- `in_sof` with `in_valid` = 0: ignored.
- Reset has priority over all inputs. It returns to IDLE, clears counter and shift register, and drops any partial frame without `out_err`.

## Timing
- Reset values: `out_word` = 0, `out_valid` = 0, `out_minval` = 0, `out_err` = 0, state IDLE.
- Latency: `out_valid` asserts exactly 1 cycle after the last bit is accepted.
- Back-to-back frames:
  - `in_sof` may arrive in the cycle right after the last bit, or the same cycle `out_valid` is high.
  - The new frame is accepted with no bubble.
  - Sustained throughput is one word per WIDTH cycles.
- `out_valid`, `out_err` and `out_minval` are registered outputs. No combinational path from inputs to outputs.
- `out_valid` and `out_err` never assert in the same cycle.

## Test plan
- Reset, then stream 1,0,1,1,1,1,1,1 (0xFD, WIDTH=8) with `in_sof` on the first bit, `in_valid` continuous → `out_word` = 0x03, `out_valid` pulse 1 cycle after bit 7, `out_minval` = 0.
- Stream of all zeros → 0x00. Then back-to-back stream 0,0,0,0,0,0,0,1 (0x80) → `out_word` = 0x80 with `out_minval` = 1; two `out_valid` pulses exactly 8 cycles apart.
- Stream 0xFD with random `in_valid` gaps of 1–5 cycles → 0x03. `out_valid` 1 cycle after the last accepted bit; no output during stalls.
- Accept 3 bits, then `in_sof` with a fresh 0x02 stream (0,1,1,1,1,1,1,1 = 0xFE) → `out_err` pulse 1 cycle after the restart bit, then `out_word` = 0x02; no `out_valid` for the aborted frame.
- Bits with `in_valid` but no `in_sof` while IDLE → no output; `out_word` unchanged.
- Assert `rst` after 5 bits of a frame → all outputs 0, no `out_err`. A following full 0xFD frame decodes to 0x03.
